// File: rtl/riscv_axi_ar_arb.sv
// riscv_axi_ar_arb: round-robin AXI4 AR arbiter merging N_PORTS read masters, with ID-tagged R routing
module riscv_axi_ar_arb #(
    parameter int N_PORTS = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int IDW     = 4,
    parameter int MAX_OUT = 4,
    localparam int PW     = N_PORTS > 1 ? $clog2(N_PORTS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [N_PORTS-1:0]     s_arvalid,
    output logic [N_PORTS-1:0]     s_arready,
    input  logic [N_PORTS*AW-1:0]  s_araddr,
    input  logic [N_PORTS*IDW-1:0] s_arid,
    input  logic [N_PORTS*8-1:0]   s_arlen,
    output logic [N_PORTS-1:0]     s_rvalid,
    input  logic [N_PORTS-1:0]     s_rready,
    output logic [N_PORTS*DW-1:0]  s_rdata,
    output logic [N_PORTS*IDW-1:0] s_rid,
    output logic [N_PORTS*2-1:0]   s_rresp,
    output logic [N_PORTS-1:0]     s_rlast,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [AW-1:0]          m_araddr,
    output logic [PW+IDW-1:0]      m_arid,
    output logic [7:0]             m_arlen,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [DW-1:0]          m_rdata,
    input  logic [PW+IDW-1:0]      m_rid,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rlast,
    output logic [N_PORTS-1:0]     busy,
    output logic                   rid_err
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [PW:0] NP = (PW+1)'(N_PORTS);

    logic [CW-1:0]          cnt [N_PORTS];
    logic [PW-1:0]          ptr, gnt, off;
    logic [PW:0]            sum;
    logic [N_PORTS-1:0]     elig, rot, rsel, inc, dec;
    logic [2*N_PORTS-1:0]   dbl;
    logic                   found, slot_free, routable;
    logic [AW-1:0]          g_addr;
    logic [IDW-1:0]         g_id;
    logic [7:0]             g_len;

    assign s_rdata = {N_PORTS{m_rdata}};
    assign s_rid   = {N_PORTS{m_rid[IDW-1:0]}};
    assign s_rresp = {N_PORTS{m_rresp}};
    assign s_rlast = {N_PORTS{m_rlast}};

    // rotate the eligible mask by the RR pointer; lowest set bit is the next grant
    always_comb begin
        slot_free = !m_arvalid || m_arready;
        for (int i = 0; i < N_PORTS; i++) begin
            elig[i] = s_arvalid[i] && (cnt[i] < MAX_C);
            busy[i] = cnt[i] != '0;
        end
        dbl = {elig, elig} >> ptr;
        rot = dbl[N_PORTS-1:0];
        found = |rot;
        off = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        gnt = sum >= NP ? PW'(sum - NP) : sum[PW-1:0];
        s_arready = '0;
        g_addr = '0;
        g_id = '0;
        g_len = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (gnt == PW'(i)) begin
                s_arready[i] = found && slot_free;
                g_addr = s_araddr[i*AW +: AW];
                g_id = s_arid[i*IDW +: IDW];
                g_len = s_arlen[i*8 +: 8];
            end
        inc = s_arvalid & s_arready;
    end

    // beats for ports with nothing outstanding are swallowed and flagged
    always_comb begin
        for (int i = 0; i < N_PORTS; i++)
            rsel[i] = (m_rid[PW+IDW-1:IDW] == PW'(i)) && (cnt[i] != '0);
        routable = |rsel;
        s_rvalid = m_rvalid ? rsel : '0;
        m_rready = routable ? |(s_rready & rsel) : 1'b1;
        dec = (m_rvalid && m_rready && m_rlast) ? rsel : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_arvalid <= 1'b0;
            m_araddr <= '0;
            m_arid <= '0;
            m_arlen <= '0;
            ptr <= '0;
            rid_err <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) cnt[i] <= '0;
        end else begin
            rid_err <= m_rvalid && !routable;
            for (int i = 0; i < N_PORTS; i++) cnt[i] <= cnt[i] + CW'(inc[i]) - CW'(dec[i]);
            if (slot_free) begin
                m_arvalid <= found;
                if (found) begin
                    m_araddr <= g_addr;
                    m_arid <= {gnt, g_id};
                    m_arlen <= g_len;
                    ptr <= gnt == PW'(N_PORTS - 1) ? '0 : gnt + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_axi_ar_arb.sv
// tb_riscv_axi_ar_arb: directed self-checking bench for the AR arbiter and R router
module tb_riscv_axi_ar_arb;
    localparam int N = 2, AW = 32, DW = 32, IDW = 4;

    logic clk = 0, rst_n = 0;
    logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, busy;
    logic [N*AW-1:0] s_araddr;
    logic [N*IDW-1:0] s_arid, s_rid;
    logic [N*8-1:0] s_arlen;
    logic [N*DW-1:0] s_rdata;
    logic [N*2-1:0] s_rresp;
    logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, rid_err;
    logic [AW-1:0] m_araddr;
    logic [IDW:0] m_arid, m_rid;
    logic [7:0] m_arlen;
    logic [DW-1:0] m_rdata;
    logic [1:0] m_rresp;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    riscv_axi_ar_arb #(.N_PORTS(N), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUT(4)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast), .busy(busy), .rid_err(rid_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_rready = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        #3;
        tests++;
        if ({m_arvalid, m_araddr, m_arid, m_arlen} !== '0) begin
            fails++; $display("FAIL reset_ar got v=%b a=%h id=%h len=%h exp all 0", m_arvalid, m_araddr, m_arid, m_arlen);
        end
        tests++;
        if ({busy, rid_err, s_arready, s_rvalid} !== '0) begin
            fails++; $display("FAIL reset_status got busy=%b err=%b ar=%b rv=%b exp 0", busy, rid_err, s_arready, s_rvalid);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h100; s_arid[3:0] = 4'h3; m_arready = 1;
        #1;
        tests++;
        if (s_arready !== 2'b01) begin fails++; $display("FAIL single_arready got %b exp 01", s_arready); end
        tick();
        s_arvalid = '0;
        tests++;
        if (m_arvalid !== 1'b1 || m_arid !== 5'h03 || m_araddr !== 32'h100) begin
            fails++; $display("FAIL single_ar got v=%b id=%h a=%h exp 1 03 100", m_arvalid, m_arid, m_araddr);
        end
        tests++;
        if (busy !== 2'b01) begin fails++; $display("FAIL single_busy got %b exp 01", busy); end
        tick();
        tests++;
        if (m_arvalid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", m_arvalid); end
        m_rvalid = 1; m_rid = 5'h03; m_rlast = 1; m_rdata = 32'hCAFE; s_rready = 2'b01;
        #1;
        tests++;
        if (s_rvalid !== 2'b01 || m_rready !== 1'b1 || s_rdata[31:0] !== 32'hCAFE) begin
            fails++; $display("FAIL single_r got rv=%b rr=%b d=%h exp 01 1 cafe", s_rvalid, m_rready, s_rdata[31:0]);
        end
        tick();
        m_rvalid = 0;
        tests++;
        if (busy !== 2'b00) begin fails++; $display("FAIL single_busy_clr got %b exp 00", busy); end
    endtask

    task automatic test_contention;
        logic [1:0] e;
        do_reset();
        s_arvalid = 2'b11; m_arready = 1;
        s_araddr = {32'h2000, 32'h1000}; s_arid = {4'h2, 4'h1};
        for (int k = 0; k < 4; k++) begin
            e = k[0] ? 2'b10 : 2'b01;
            #1;
            tests++;
            if (s_arready !== e) begin fails++; $display("FAIL rr_grant%0d got %b exp %b", k, s_arready, e); end
            tick();
            tests++;
            if (m_arid !== {k[0], k[0] ? 4'h2 : 4'h1}) begin
                fails++; $display("FAIL rr_arid%0d got %h exp %h", k, m_arid, {k[0], k[0] ? 4'h2 : 4'h1});
            end
        end
        s_arvalid = '0;
    endtask

    task automatic test_limit;
        do_reset();
        s_arvalid = 2'b01; m_arready = 1; s_arid = {4'h7, 4'h1};
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (s_arready !== 2'b01) begin fails++; $display("FAIL limit_grant%0d got %b exp 01", k, s_arready); end
            tick();
        end
        tests++;
        if (s_arready !== 2'b00 || busy !== 2'b01) begin
            fails++; $display("FAIL limit_full got ar=%b busy=%b exp 00 01", s_arready, busy);
        end
        s_arvalid = 2'b11;
        #1;
        tests++;
        if (s_arready !== 2'b10) begin fails++; $display("FAIL limit_other got %b exp 10", s_arready); end
        tick();
        s_arvalid = 2'b01;
        tests++;
        if (m_arid !== 5'h17) begin fails++; $display("FAIL limit_arid got %h exp 17", m_arid); end
        #1;
        tests++;
        if (s_arready !== 2'b00) begin fails++; $display("FAIL limit_still got %b exp 00", s_arready); end
        m_rvalid = 1; m_rid = 5'h01; m_rlast = 1; s_rready = 2'b01;
        tick();
        m_rvalid = 0;
        #1;
        tests++;
        if (s_arready !== 2'b01) begin fails++; $display("FAIL limit_release got %b exp 01", s_arready); end
        s_arvalid = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h200; s_arid[3:0] = 4'h5;
        tick();
        s_araddr[31:0] = 32'h300;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (m_arvalid !== 1'b1 || m_araddr !== 32'h200 || m_arid !== 5'h05 || s_arready !== 2'b00) begin
                fails++; $display("FAIL bp_hold%0d got v=%b a=%h id=%h ar=%b exp 1 200 05 00", k, m_arvalid, m_araddr, m_arid, s_arready);
            end
            tick();
        end
        m_arready = 1;
        #1;
        tests++;
        if (s_arready !== 2'b01) begin fails++; $display("FAIL bp_release got %b exp 01", s_arready); end
        tick();
        s_arvalid = '0;
        tests++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h300) begin
            fails++; $display("FAIL bp_next got v=%b a=%h exp 1 300", m_arvalid, m_araddr);
        end
    endtask

    task automatic test_interleave;
        do_reset();
        m_arready = 1; s_arvalid = 2'b11; s_arid = {4'h2, 4'h1}; s_arlen = {8'd3, 8'd0};
        tick();
        s_arvalid = 2'b10;
        tick();
        s_arvalid = '0;
        tick();
        s_rready = 2'b11; m_rvalid = 1; m_rid = 5'h12; m_rdata = 32'hA1; m_rlast = 0;
        #1;
        tests++;
        if (s_rvalid !== 2'b10 || s_rdata[63:32] !== 32'hA1 || s_rid[7:4] !== 4'h2) begin
            fails++; $display("FAIL il_b1 got rv=%b d=%h id=%h exp 10 a1 2", s_rvalid, s_rdata[63:32], s_rid[7:4]);
        end
        tick();
        m_rid = 5'h01; m_rdata = 32'hB0; m_rlast = 1; s_arvalid = 2'b01;
        #1;
        tests++;
        if (s_rvalid !== 2'b01 || s_arready !== 2'b01 || s_rdata[31:0] !== 32'hB0) begin
            fails++; $display("FAIL il_b2 got rv=%b ar=%b d=%h exp 01 01 b0", s_rvalid, s_arready, s_rdata[31:0]);
        end
        tick();
        s_arvalid = '0;
        tests++;
        if (busy !== 2'b11) begin fails++; $display("FAIL il_cnt0 got %b exp 11", busy); end
        m_rid = 5'h12; m_rdata = 32'hA2; m_rlast = 0; s_rready = 2'b01;
        #1;
        tests++;
        if (m_rready !== 1'b0 || s_rvalid !== 2'b10) begin
            fails++; $display("FAIL il_bp got rr=%b rv=%b exp 0 10", m_rready, s_rvalid);
        end
        s_rready = 2'b11;
        #1;
        tests++;
        if (m_rready !== 1'b1) begin fails++; $display("FAIL il_rr got %b exp 1", m_rready); end
        tick();
        m_rdata = 32'hA3;
        tick();
        m_rdata = 32'hA4; m_rlast = 1;
        tick();
        m_rvalid = 0;
        tests++;
        if (busy !== 2'b01) begin fails++; $display("FAIL il_p1done got %b exp 01", busy); end
        m_rvalid = 1; m_rid = 5'h01; m_rlast = 1;
        tick();
        m_rvalid = 0;
        tests++;
        if (busy !== 2'b00) begin fails++; $display("FAIL il_p0done got %b exp 00", busy); end
    endtask

    task automatic test_err;
        do_reset();
        m_rvalid = 1; m_rid = 5'h13; m_rlast = 1; s_rready = 2'b00;
        #1;
        tests++;
        if (m_rready !== 1'b1 || s_rvalid !== 2'b00) begin
            fails++; $display("FAIL err_drop got rr=%b rv=%b exp 1 00", m_rready, s_rvalid);
        end
        tick();
        m_rvalid = 0;
        tests++;
        if (rid_err !== 1'b1 || busy !== 2'b00) begin
            fails++; $display("FAIL err_pulse got err=%b busy=%b exp 1 00", rid_err, busy);
        end
        tick();
        tests++;
        if (rid_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b exp 0", rid_err); end
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h100; s_arid[3:0] = 4'h3; m_arready = 0;
        tick();
        s_arvalid = '0;
        tests++;
        if (m_arvalid !== 1'b1 || busy !== 2'b01) begin
            fails++; $display("FAIL err_pre got v=%b busy=%b exp 1 01", m_arvalid, busy);
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if ({m_arvalid, m_araddr, m_arid, busy, rid_err} !== '0) begin
            fails++; $display("FAIL err_async_rst got v=%b a=%h id=%h busy=%b exp 0", m_arvalid, m_araddr, m_arid, busy);
        end
        tick();
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_limit();
        test_backpressure();
        test_interleave();
        test_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
